lemmings_multi_fsm: RTL and testbench

- Array of NUM_LEM independent Lemmings walker controllers sharing one clock and reset.
- Each lane is a Moore machine with these states: walk left/right, fall, dig and splat.
- Fall duration is measured per lane, and a long fall is fatal.
- A population counter reports dead lanes; the game-logic top level uses it for status and end-of-level detection.

---
 rtl/lemmings_multi_fsm_if.sv | 30 +++
 rtl/lemmings_multi_fsm.sv | 120 ++++++++++++
 tb/tb_lemmings_multi_fsm.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/lemmings_multi_fsm_if.sv
// Lane-vector bus between the game logic and the lemmings controller array.
// The game logic drives the per-lane sensors and commands; the controller
// array returns the per-lane animation flags and the dead-lane population.
interface lemmings_multi_fsm_if #(
    parameter int NUM_LEM = 4
);
    localparam int POP_W = $clog2(NUM_LEM + 1);

    logic [NUM_LEM-1:0] bump_left;
    logic [NUM_LEM-1:0] bump_right;
    logic [NUM_LEM-1:0] ground;
    logic [NUM_LEM-1:0] dig;
    logic [NUM_LEM-1:0] walk_left;
    logic [NUM_LEM-1:0] walk_right;
    logic [NUM_LEM-1:0] aaah;
    logic [NUM_LEM-1:0] digging;
    logic [POP_W-1:0]   dead_count;

    // Game logic side
    modport master (
        output bump_left, bump_right, ground, dig,
        input  walk_left, walk_right, aaah, digging, dead_count
    );

    // Controller array side
    modport slave (
        input  bump_left, bump_right, ground, dig,
        output walk_left, walk_right, aaah, digging, dead_count
    );
endinterface

// File: rtl/lemmings_multi_fsm.sv
// Array of independent Lemmings walker controllers. Each lane walks, digs,
// falls and may splat after a long fall; a population count of splatted lanes
// feeds the level-status logic. Outputs are decoded from the next state and
// registered, so they depend on stored state only.
module lemmings_multi_fsm #(
    parameter int NUM_LEM      = 4,
    parameter int SPLAT_CYCLES = 20
) (
    input  logic                  clk,
    input  logic                  areset,
    lemmings_multi_fsm_if.slave   bus
);
    localparam int CNT_W = $clog2(SPLAT_CYCLES + 2);
    localparam int POP_W = $clog2(NUM_LEM + 1);

    // Saturation value: one past the survivable fall length, so reaching it
    // means "too long" and the counter can never wrap back to a safe value.
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(SPLAT_CYCLES + 1);

    typedef enum logic [2:0] {
        WL,
        WR,
        FALL_L,
        FALL_R,
        DIG_L,
        DIG_R,
        SPLAT
    } state_e;

    state_e             state_q [NUM_LEM];
    state_e             state_d [NUM_LEM];
    logic [CNT_W-1:0]   cnt_q   [NUM_LEM];
    logic [CNT_W-1:0]   cnt_d   [NUM_LEM];

    logic [NUM_LEM-1:0] walk_left_q,  walk_left_d;
    logic [NUM_LEM-1:0] walk_right_q, walk_right_d;
    logic [NUM_LEM-1:0] aaah_q,       aaah_d;
    logic [NUM_LEM-1:0] digging_q,    digging_d;
    logic [POP_W-1:0]   dead_count_q, dead_count_d;

    // Per-lane next state, fall counter and output decode of the next state.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves a value unassigned and no latch is inferred.
        walk_left_d  = '0;
        walk_right_d = '0;
        aaah_d       = '0;
        digging_d    = '0;
        dead_count_d = '0;
        for (int i = 0; i < NUM_LEM; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                WL: begin
                    if (!bus.ground[i])        state_d[i] = FALL_L;
                    else if (bus.dig[i])       state_d[i] = DIG_L;
                    else if (bus.bump_left[i]) state_d[i] = WR;
                end
                WR: begin
                    if (!bus.ground[i])         state_d[i] = FALL_R;
                    else if (bus.dig[i])        state_d[i] = DIG_R;
                    else if (bus.bump_right[i]) state_d[i] = WL;
                end
                DIG_L: if (!bus.ground[i]) state_d[i] = FALL_L;
                DIG_R: if (!bus.ground[i]) state_d[i] = FALL_R;
                FALL_L: if (bus.ground[i]) state_d[i] = (cnt_q[i] == CNT_SAT) ? SPLAT : WL;
                FALL_R: if (bus.ground[i]) state_d[i] = (cnt_q[i] == CNT_SAT) ? SPLAT : WR;
                SPLAT:  state_d[i] = SPLAT;
                default: state_d[i] = WL;
            endcase

            // Counter holds the number of cycles spent falling, including the
            // upcoming one; it starts at 1 on entry because it is 0 outside a fall.
            if (state_d[i] inside {FALL_L, FALL_R})
                cnt_d[i] = (cnt_q[i] == CNT_SAT) ? cnt_q[i] : cnt_q[i] + 1'b1;
            else
                cnt_d[i] = '0;

            walk_left_d[i]  = (state_d[i] == WL);
            walk_right_d[i] = (state_d[i] == WR);
            aaah_d[i]       = (state_d[i] inside {FALL_L, FALL_R});
            digging_d[i]    = (state_d[i] inside {DIG_L, DIG_R});
            if (state_d[i] == SPLAT)
                dead_count_d = dead_count_d + 1'b1;
        end
    end

    // State, fall counters and registered Moore outputs; reset puts every lane in WL.
    always_ff @(posedge clk or posedge areset) begin
        // NOTE: state registers use non-blocking assignments so every lane
        // samples the pre-edge values regardless of statement order.
        if (areset) begin
            for (int i = 0; i < NUM_LEM; i++) begin
                state_q[i] <= WL;
                cnt_q[i]   <= '0;
            end
            walk_left_q  <= '1;
            walk_right_q <= '0;
            aaah_q       <= '0;
            digging_q    <= '0;
            dead_count_q <= '0;
        end else begin
            for (int i = 0; i < NUM_LEM; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            walk_left_q  <= walk_left_d;
            walk_right_q <= walk_right_d;
            aaah_q       <= aaah_d;
            digging_q    <= digging_d;
            dead_count_q <= dead_count_d;
        end
    end

    assign bus.walk_left  = walk_left_q;
    assign bus.walk_right = walk_right_q;
    assign bus.aaah       = aaah_q;
    assign bus.digging    = digging_q;
    assign bus.dead_count = dead_count_q;

endmodule

// File: tb/tb_lemmings_multi_fsm.sv
// Scoreboard bench for lemmings_multi_fsm: the driver applies one cycle of
// stimulus, advances a behavioural lane model and queues the expected outputs;
// an independent monitor pops and compares after every rising edge.
module tb_lemmings_multi_fsm;
    localparam int NUM_LEM      = 4;
    localparam int SPLAT_CYCLES = 20;

    localparam int M_WALK = 0;
    localparam int M_FALL = 1;
    localparam int M_DIG  = 2;
    localparam int M_DEAD = 3;

    logic clk;
    logic areset;

    lemmings_multi_fsm_if #(.NUM_LEM(NUM_LEM)) bus ();

    lemmings_multi_fsm #(
        .NUM_LEM      (NUM_LEM),
        .SPLAT_CYCLES (SPLAT_CYCLES)
    ) dut (
        .clk    (clk),
        .areset (areset),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: per lane an activity, a heading (0 = left) and fall time so far.
    int mode      [NUM_LEM];
    bit dir       [NUM_LEM];
    int fall_time [NUM_LEM];

    logic [23:0] exp_q [$];
    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h (wl,wr,aaah,dig,dead)", name, got, exp);
        end
    endtask

    function automatic logic [23:0] dut_outs();
        return {bus.walk_left, bus.walk_right, bus.aaah, bus.digging, 8'(bus.dead_count)};
    endfunction

    function automatic logic [23:0] model_outs();
        logic [NUM_LEM-1:0] wl, wr, fa, dg;
        int dead;
        wl = '0; wr = '0; fa = '0; dg = '0; dead = 0;
        for (int i = 0; i < NUM_LEM; i++) begin
            wl[i] = (mode[i] == M_WALK) && !dir[i];
            wr[i] = (mode[i] == M_WALK) &&  dir[i];
            fa[i] = (mode[i] == M_FALL);
            dg[i] = (mode[i] == M_DIG);
            if (mode[i] == M_DEAD) dead++;
        end
        return {wl, wr, fa, dg, 8'(dead)};
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NUM_LEM; i++) begin
            mode[i] = M_WALK; dir[i] = 1'b0; fall_time[i] = 0;
        end
    endfunction

    function automatic void model_step(input logic [NUM_LEM-1:0] bl, br, g, d);
        for (int i = 0; i < NUM_LEM; i++) begin
            case (mode[i])
                M_WALK: begin
                    if (!g[i]) begin mode[i] = M_FALL; fall_time[i] = 1; end
                    else if (d[i]) mode[i] = M_DIG;
                    else if (!dir[i] && bl[i]) dir[i] = 1'b1;
                    else if (dir[i] && br[i])  dir[i] = 1'b0;
                end
                M_DIG: if (!g[i]) begin mode[i] = M_FALL; fall_time[i] = 1; end
                M_FALL: begin
                    if (!g[i]) fall_time[i]++;
                    else if (fall_time[i] > SPLAT_CYCLES) mode[i] = M_DEAD;
                    else mode[i] = M_WALK;
                end
                default: ;
            endcase
        end
    endfunction

    // One clock of stimulus; called between a falling and the next rising edge.
    task automatic cycle(input logic [NUM_LEM-1:0] bl, br, g, d);
        bus.bump_left  = bl;
        bus.bump_right = br;
        bus.ground     = g;
        bus.dig        = d;
        model_step(bl, br, g, d);
        exp_q.push_back(model_outs());
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic [NUM_LEM-1:0] g);
        for (int k = 0; k < n; k++) cycle('0, '0, g, '0);
    endtask

    // Asynchronous reset pulse placed between edges; outputs must follow at once.
    task automatic pulse_reset(input string name);
        #2 areset = 1'b1;
        model_reset();
        #1 check(name, dut_outs(), model_outs());
        #1 areset = 1'b0;
    endtask

    // Monitor: compares each DUT output vector with the oldest queued expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                logic [23:0] e;
                e = exp_q.pop_front();
                check($sformatf("cycle%0d", cyc), dut_outs(), e);
                cyc++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hole [NUM_LEM];
        logic [NUM_LEM-1:0] bl, br, g, d;

        areset = 1'b1;
        bus.bump_left = '0; bus.bump_right = '0; bus.ground = '1; bus.dig = '0;
        model_reset();
        repeat (2) @(negedge clk);
        areset = 1'b0;

        // Reset and bump behaviour
        pulse_reset("reset_async");
        cycle(4'b0001, 4'b0000, 4'b1111, 4'b0000);
        cycle(4'b0000, 4'b0011, 4'b1111, 4'b0000);
        cycle(4'b0011, 4'b0011, 4'b1111, 4'b0000);   // both bumps in WL -> WR
        cycle(4'b0000, 4'b0011, 4'b1111, 4'b0000);

        // Lane2 heads right, falls exactly SPLAT_CYCLES cycles and survives
        cycle(4'b0100, 4'b0000, 4'b1111, 4'b0000);
        idle(SPLAT_CYCLES, 4'b1011);
        idle(2, 4'b1111);

        // Lane1 falls one cycle too long and splats; later activity is ignored
        idle(SPLAT_CYCLES + 1, 4'b1101);
        idle(1, 4'b1111);
        cycle(4'b0010, 4'b0010, 4'b1101, 4'b0010);
        cycle(4'b0010, 4'b0000, 4'b1111, 4'b0010);
        cycle(4'b0000, 4'b0010, 4'b1101, 4'b0000);
        pulse_reset("reset_revive");
        idle(1, 4'b1111);

        // Lane3 digs (bump ignored), then falls briefly and resumes WL
        cycle(4'b1000, 4'b0000, 4'b1111, 4'b1000);
        cycle(4'b1000, 4'b1000, 4'b1111, 4'b1000);
        idle(3, 4'b0111);
        idle(1, 4'b1111);

        // Fall has priority over dig and bump on lane0
        cycle(4'b0001, 4'b0000, 4'b1110, 4'b0001);
        idle(1, 4'b1111);

        // Very long fall saturates the counter and still splats
        idle(100, 4'b1110);
        idle(2, 4'b1111);
        pulse_reset("reset_after_splat");

        // Reset mid-fall, then a survivable fall
        idle(15, 4'b1110);
        pulse_reset("reset_mid_fall");
        idle(SPLAT_CYCLES, 4'b1110);
        idle(2, 4'b1111);

        // Randomised traffic with fall bursts of varying length
        for (int i = 0; i < NUM_LEM; i++) hole[i] = 0;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 79) == 0) pulse_reset("reset_random");
            for (int i = 0; i < NUM_LEM; i++) begin
                if (hole[i] == 0 && $urandom_range(0, 11) == 0)
                    hole[i] = $urandom_range(1, 26);
                g[i] = (hole[i] == 0);
                if (hole[i] > 0) hole[i]--;
                bl[i] = ($urandom_range(0, 3) == 0);
                br[i] = ($urandom_range(0, 3) == 0);
                d[i]  = ($urandom_range(0, 7) == 0);
            end
            cycle(bl, br, g, d);
        end

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk);
        #2;
        check("scoreboard_drain", 24'(exp_q.size()), 24'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
